// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key debounce array:
//   - key_state_e : per-channel press-tracking state (IDLE / PRESSED / HELD)
//   - KEY_*       : default parameter values used by key_debounce_array
//   - cnt_width() : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } key_state_e;

   localparam int KEY_N_KEYS        = 4;
   localparam int KEY_CNT_MAX       = 20'hF_FFFF;
   localparam int KEY_LONG_CYCLES   = 50_000_000;
   localparam int KEY_REPEAT_CYCLES = 10_000_000;
   localparam int KEY_REPEAT_EN     = 1;
   localparam int KEY_ACTIVE_LOW    = 0;

   // Bits needed to hold values 0..n_states-1, at least one bit.
   function automatic int cnt_width(input int n_states);
      return (n_states < 2) ? 1 : $clog2(n_states);
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// ---------------------------------------------------------------------------
// key_debounce_chan
// One key channel: polarity fix, 2-flop synchronizer, stability-count
// debouncer, and an IDLE/PRESSED/HELD tracker that emits one-clock pulses.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   sys_rst      in   asynchronous active-high reset
//   key_raw_i    in   raw asynchronous key pin
//   level_o      out  debounced pressed level
//   press_o      out  pulse on debounced 0->1
//   release_o    out  pulse on debounced 1->0
//   long_o       out  pulse when the hold reaches LONG_CYCLES
//   repeat_o     out  pulse every REPEAT_CYCLES after the long press
// ---------------------------------------------------------------------------
module key_debounce_chan
   import key_pkg::*;
#(
   parameter int CNT_MAX       = KEY_CNT_MAX,
   parameter int LONG_CYCLES   = KEY_LONG_CYCLES,
   parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES,
   parameter int REPEAT_EN     = KEY_REPEAT_EN,
   parameter int ACTIVE_LOW    = KEY_ACTIVE_LOW
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o
);

   localparam int W_DB   = cnt_width(CNT_MAX + 1);
   localparam int W_HOLD = cnt_width(LONG_CYCLES);
   localparam int W_REP  = cnt_width(REPEAT_CYCLES);

   localparam logic [W_DB-1:0]   DB_MAX    = W_DB'(CNT_MAX);
   localparam logic [W_HOLD-1:0] HOLD_LAST = W_HOLD'(LONG_CYCLES - 1);
   localparam logic [W_REP-1:0]  REP_LAST  = W_REP'(REPEAT_CYCLES - 1);

   // ---------------- synchronizer + debouncer ----------------
   logic              key_act;
   logic [1:0]        sync_q;
   logic [W_DB-1:0]   db_cnt_q, db_cnt_d;
   logic              level_q, level_d;
   logic              db_stable;

   // Internally "pressed" is always 1; reset value 0 is therefore the
   // inactive level regardless of pin polarity.
   assign key_act = (ACTIVE_LOW != 0) ? ~key_raw_i : key_raw_i;

   always_comb begin
      db_stable = (sync_q[0] == sync_q[1]);
      db_cnt_d  = '0;
      if (db_stable) begin
         db_cnt_d = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
      end
      // The counter only clears one clock after sync[0] moves, so the load
      // is also gated on the stages agreeing; otherwise a saturated counter
      // would let a fresh edge straight through to the level.
      level_d = level_q;
      if (db_stable && (db_cnt_q == DB_MAX)) begin
         level_d = sync_q[0];
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_q   <= 2'b00;
         db_cnt_q <= '0;
         level_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], key_act};
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
      end
   end

   // ---------------- press tracker FSM ----------------
   key_state_e        state_q, state_d;
   logic [W_HOLD-1:0] hold_q, hold_d;
   logic [W_REP-1:0]  rep_q, rep_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   logic              repeat_q, repeat_d;

   // State register (with counters and registered pulses)
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         rep_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
      end
   end

   // Next-state logic; a falling level always wins over the long transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (level_q) state_d = PRESSED;
         end
         PRESSED: begin
            if (!level_q)                state_d = IDLE;
            else if (hold_q == HOLD_LAST) state_d = HELD;
         end
         HELD: begin
            if (!level_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / counter logic. Release is checked first in every held state,
   // which keeps the four pulses mutually exclusive.
   always_comb begin
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      hold_d    = hold_q;
      rep_d     = rep_q;
      case (state_q)
         IDLE: begin
            hold_d  = '0;
            rep_d   = '0;
            press_d = level_q;
         end
         PRESSED: begin
            if (!level_q) begin
               release_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               long_d = 1'b1;
               rep_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         HELD: begin
            if (!level_q) begin
               release_d = 1'b1;
            end else if (rep_q == REP_LAST) begin
               rep_d    = '0;
               repeat_d = (REPEAT_EN != 0);
            end else begin
               rep_d = rep_q + 1'b1;
            end
         end
         default: begin
            hold_d = '0;
            rep_d  = '0;
         end
      endcase
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// ---------------------------------------------------------------------------
// key_debounce_array
// N_KEYS independent debounced key channels with press / release /
// long-press / auto-repeat event pulses.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   sys_rst      in   asynchronous active-high reset
//   key_in       in   [N_KEYS] raw asynchronous key pins
//   key_level    out  [N_KEYS] debounced pressed level
//   key_press    out  [N_KEYS] one-clock pulse on debounced 0->1
//   key_release  out  [N_KEYS] one-clock pulse on debounced 1->0
//   key_long     out  [N_KEYS] one-clock pulse when hold reaches LONG_CYCLES
//   key_repeat   out  [N_KEYS] one-clock pulse every REPEAT_CYCLES after long
// ---------------------------------------------------------------------------
module key_debounce_array
   import key_pkg::*;
#(
   parameter int N_KEYS        = KEY_N_KEYS,
   parameter int CNT_MAX       = KEY_CNT_MAX,
   parameter int LONG_CYCLES   = KEY_LONG_CYCLES,
   parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES,
   parameter int REPEAT_EN     = KEY_REPEAT_EN,
   parameter int ACTIVE_LOW    = KEY_ACTIVE_LOW
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_repeat
);

   for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
      key_debounce_chan #(
         .CNT_MAX       (CNT_MAX),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .REPEAT_EN     (REPEAT_EN),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_chan (
         .sys_clk   (sys_clk),
         .sys_rst   (sys_rst),
         .key_raw_i (key_in[gi]),
         .level_o   (key_level[gi]),
         .press_o   (key_press[gi]),
         .release_o (key_release[gi]),
         .long_o    (key_long[gi]),
         .repeat_o  (key_repeat[gi])
      );
   end

endmodule

// File: tb/tb_key_debounce_array.sv
module tb_key_debounce_array;

   localparam int NK  = 4;
   localparam int LAT = 7;    // sample edge -> press/release pulse
   localparam int LNG = 20;
   localparam int REP = 8;

   localparam int K_LUP = 0, K_LDN = 1, K_PRS = 2, K_REL = 3, K_LNG = 4, K_RPT = 5;

   typedef struct {
      int         due;
      int         dut;   // 0 = active-high DUT, 1 = active-low DUT
      int         kind;
      logic [3:0] mask;
   } ev_t;

   typedef struct {
      logic [3:0] mask;
      int         hold;
      bit         exp_press;
      bit         exp_long;
      int         n_rep;
   } vec_t;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [NK-1:0] key_in    = '0;
   logic [NK-1:0] key_in_al = '1;
   logic [NK-1:0] m_lvl, m_prs, m_rel, m_lng, m_rpt;
   logic [NK-1:0] a_lvl, a_prs, a_rel, a_lng, a_rpt;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   ev_t  sb_q[$];
   ev_t  keep_q[$];
   logic [3:0] e_lvl[2];
   logic [3:0] e_prs[2], e_rel[2], e_lng[2], e_rpt[2];
   vec_t vecs[10];

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   key_debounce_array #(
      .N_KEYS(NK), .CNT_MAX(4), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP),
      .REPEAT_EN(1), .ACTIVE_LOW(0)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
      .key_level(m_lvl), .key_press(m_prs), .key_release(m_rel),
      .key_long(m_lng), .key_repeat(m_rpt)
   );

   key_debounce_array #(
      .N_KEYS(NK), .CNT_MAX(4), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP),
      .REPEAT_EN(1), .ACTIVE_LOW(1)
   ) dut_al (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in_al),
      .key_level(a_lvl), .key_press(a_prs), .key_release(a_rel),
      .key_long(a_lng), .key_repeat(a_rpt)
   );

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
      end
   endtask

   task automatic push(input int due, input int d, input int kind, input logic [3:0] mask);
      ev_t e;
      e.due = due; e.dut = d; e.kind = kind; e.mask = mask;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   // Scoreboard monitor: pops events due this cycle and compares every output.
   always @(negedge sys_clk) begin
      for (int d = 0; d < 2; d++) begin
         e_prs[d] = '0; e_rel[d] = '0; e_lng[d] = '0; e_rpt[d] = '0;
         if (sys_rst) e_lvl[d] = '0;
      end
      keep_q.delete();
      foreach (sb_q[i]) begin
         if (sb_q[i].due == cyc) begin
            case (sb_q[i].kind)
               K_LUP:   e_lvl[sb_q[i].dut] = e_lvl[sb_q[i].dut] | sb_q[i].mask;
               K_LDN:   e_lvl[sb_q[i].dut] = e_lvl[sb_q[i].dut] & ~sb_q[i].mask;
               K_PRS:   e_prs[sb_q[i].dut] = e_prs[sb_q[i].dut] | sb_q[i].mask;
               K_REL:   e_rel[sb_q[i].dut] = e_rel[sb_q[i].dut] | sb_q[i].mask;
               K_LNG:   e_lng[sb_q[i].dut] = e_lng[sb_q[i].dut] | sb_q[i].mask;
               default: e_rpt[sb_q[i].dut] = e_rpt[sb_q[i].dut] | sb_q[i].mask;
            endcase
         end else if (sb_q[i].due < cyc) begin
            n_checks++;
            n_err++;
            $display("FAIL stale_event cyc=%0d actual=missed required=due_%0d", cyc, sb_q[i].due);
         end else begin
            keep_q.push_back(sb_q[i]);
         end
      end
      sb_q = keep_q;
      chk("level",      m_lvl, e_lvl[0]);
      chk("press",      m_prs, e_prs[0]);
      chk("release",    m_rel, e_rel[0]);
      chk("long",       m_lng, e_lng[0]);
      chk("repeat",     m_rpt, e_rpt[0]);
      chk("al_level",   a_lvl, e_lvl[1]);
      chk("al_press",   a_prs, e_prs[1]);
      chk("al_release", a_rel, e_rel[1]);
      chk("al_long",    a_lng, e_lng[1]);
      chk("al_repeat",  a_rpt, e_rpt[1]);
   end

   initial begin
      int c, t, r;

      // {mask, hold clocks, press?, long?, repeats}
      vecs[0] = '{4'b0001, 12, 1'b1, 1'b0, 0};  // basic press/release
      vecs[1] = '{4'b0010,  3, 1'b0, 1'b0, 0};  // short glitch
      vecs[2] = '{4'b0100, 60, 1'b1, 1'b1, 4};  // long + repeats, 5th repeat hits release
      vecs[3] = '{4'b1000, 20, 1'b1, 1'b0, 0};  // release on the long-press clock
      vecs[4] = '{4'b0001, 28, 1'b1, 1'b1, 0};  // release on first repeat clock
      vecs[5] = '{4'b0100,  4, 1'b0, 1'b0, 0};  // glitch of CNT_MAX clocks
      vecs[6] = '{4'b1011, 10, 1'b1, 1'b0, 0};  // simultaneous channels
      vecs[7] = '{4'b1000, 21, 1'b1, 1'b1, 0};  // release one clock after long
      vecs[8] = '{4'b0001, 36, 1'b1, 1'b1, 1};  // release on second repeat clock
      vecs[9] = '{4'b0010, 27, 1'b1, 1'b1, 0};  // long then quick release

      step(3);
      sys_rst = 1'b0;
      step(2);

      // Active-low channel 1 press while other pins sit at inactive high.
      c = cyc; t = c + 1;
      key_in_al = 4'b1101;
      push(t + LAT - 1, 1, K_LUP, 4'b0010);
      push(t + LAT,     1, K_PRS, 4'b0010);
      step(12);
      key_in_al = 4'b1111;
      r = t + 12;
      push(r + LAT - 1, 1, K_LDN, 4'b0010);
      push(r + LAT,     1, K_REL, 4'b0010);
      step(25);
      $display("txn al_press ch1 start=%0d", t);

      for (int v = 0; v < 10; v++) begin
         c = cyc; t = c + 1;
         key_in = key_in | vecs[v].mask;
         r = t + vecs[v].hold;
         if (vecs[v].exp_press) begin
            push(t + LAT - 1, 0, K_LUP, vecs[v].mask);
            push(t + LAT,     0, K_PRS, vecs[v].mask);
            push(r + LAT - 1, 0, K_LDN, vecs[v].mask);
            push(r + LAT,     0, K_REL, vecs[v].mask);
         end
         if (vecs[v].exp_long) push(t + LAT + LNG, 0, K_LNG, vecs[v].mask);
         for (int k = 1; k <= vecs[v].n_rep; k++)
            push(t + LAT + LNG + k * REP, 0, K_RPT, vecs[v].mask);
         step(vecs[v].hold);
         key_in = key_in & ~vecs[v].mask;
         step(25);
         $display("txn vec=%0d mask=%b hold=%0d press=%0d long=%0d reps=%0d",
                  v, vecs[v].mask, vecs[v].hold, vecs[v].exp_press,
                  vecs[v].exp_long, vecs[v].n_rep);
      end

      // Reset while channel 0 is in HELD: silent abort, then a fresh press.
      c = cyc; t = c + 1;
      key_in[0] = 1'b1;
      push(t + LAT - 1,         0, K_LUP, 4'b0001);
      push(t + LAT,             0, K_PRS, 4'b0001);
      push(t + LAT + LNG,       0, K_LNG, 4'b0001);
      push(t + LAT + LNG + REP, 0, K_RPT, 4'b0001);
      step(39);
      sys_rst = 1'b1;
      sb_q.delete();
      step(3);
      sys_rst = 1'b0;
      c = cyc; t = c + 1;
      push(t + LAT - 1, 0, K_LUP, 4'b0001);
      push(t + LAT,     0, K_PRS, 4'b0001);
      step(12);
      key_in[0] = 1'b0;
      r = t + 12;
      push(r + LAT - 1, 0, K_LDN, 4'b0001);
      push(r + LAT,     0, K_REL, 4'b0001);
      step(25);
      $display("txn reset_mid_hold restart=%0d", t);

      n_checks++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL pending_events actual=%0d required=0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter N_KEYS, 4, number of independent key channels (1..32).
REQ-002 Parameter CNT_MAX, 20'hF_FFFF, debounce stability count in clocks; width W_DB = $clog2(CNT_MAX+1).
REQ-003 Parameter LONG_CYCLES, 50_000_000, clocks of debounced hold before the long-press event (must exceed 1).
REQ-004 Parameter REPEAT_CYCLES, 10_000_000, auto-repeat period in clocks after long press (must exceed 1).
REQ-005 Parameter REPEAT_EN, 1, 1 = auto-repeat enabled, 0 = no key_repeat pulses.
REQ-006 Parameter ACTIVE_LOW, 0, 1 = raw key_in asserted when low; internally inverted so "pressed" = 1.
REQ-007 sys_clk  input  1  single system clock, all logic on rising edge.
REQ-008 sys_rst  input  1  reset, asynchronous and active-high.
REQ-009 key_in  input  N_KEYS  raw asynchronous key pins.
REQ-010 key_level  output  N_KEYS  debounced pressed level per channel.
REQ-011 key_press  output  N_KEYS  one-clock pulse on debounced 0->1.
REQ-012 key_release  output  N_KEYS  one-clock pulse on debounced 1->0.
REQ-013 key_long  output  N_KEYS  one-clock pulse when hold reaches LONG_CYCLES.
REQ-014 key_repeat  output  N_KEYS  one-clock pulse every REPEAT_CYCLES while held after long press.

Function
REQ-015 Each channel SHALL pass key_in (after ACTIVE_LOW inversion) through a 2-flop synchronizer sync[1:0].
REQ-016 Debounce counter SHALL clear when sync[0] != sync[1], else increment, saturating at CNT_MAX.
REQ-017 key_level SHALL load sync[0] on every clock where counter == CNT_MAX; otherwise hold.
REQ-018 Latency: raw input stable from edge t -> key_level changes at edge t+CNT_MAX+2; key_press/key_release asserted at edge t+CNT_MAX+3.
REQ-019 A glitch shorter than CNT_MAX+1 clocks SHALL produce no change on any output.
REQ-020 Per-channel FSM states IDLE, PRESSED, HELD; reset state IDLE.
REQ-021 IDLE -> PRESSED on key_level rise (same edge key_press asserts); hold counter cleared.
REQ-022 PRESSED: hold counter increments each clock; at count LONG_CYCLES-1 assert key_long for one clock, go HELD, clear repeat counter.
REQ-023 HELD: repeat counter increments, wraps at REPEAT_CYCLES-1 with one-clock key_repeat pulse (first pulse REPEAT_CYCLES clocks after key_long); suppressed when REPEAT_EN=0.
REQ-024 Any state -> IDLE on key_level fall, with key_release pulse; release takes priority over a coinciding key_long/key_repeat (those suppressed that clock).
REQ-025 At most one of key_press, key_release, key_long, key_repeat SHALL be high per channel per clock.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels all reported in the same clock.
REQ-027 Counters SHALL never wrap past their terminal value; widths sized by $clog2 of the parameter.

Reset
REQ-028 While sys_rst=1, all synchronizer flops SHALL hold the inactive level, all counters 0, FSM IDLE, all outputs 0.
REQ-029 Reset asserted mid-hold SHALL abort silently (no key_release); a key held through reset deassertion SHALL produce a normal key_press after the REQ-018 latency.
REQ-030 ACTIVE_LOW=1 with key_in held high through reset SHALL produce no event.

Structure
REQ-031 Shared package key_pkg SHALL hold the FSM state enum (IDLE/PRESSED/HELD) and default parameter constants.
REQ-032 One sub-module key_debounce_chan (one channel: sync, debounce, FSM, pulses), instantiated N_KEYS times by generate.

Verification (N_KEYS=4, CNT_MAX=4, LONG_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1)
REQ-033 key_in[0] 0->1 held -> key_level[0]=1 at edge 6, key_press[0] single pulse at edge 7, other channels silent.
REQ-034 key_in[1] high 3 clocks then low -> no output change on any channel.
REQ-035 key_in[2] held 60 clocks -> key_press, key_long 20 clocks after key_press, then key_repeat every 8 clocks; key_release at release+7.
REQ-036 key_in[3] released exactly on the long-press clock -> key_release only, no key_long.
REQ-037 sys_rst pulsed while key_in[0] held in HELD -> all outputs 0 immediately, no key_release; key_press 7 clocks after reset release.
REQ-038 ACTIVE_LOW=1, all key_in=1 through reset, then key_in[1]=0 -> only channel 1 press after 7 clocks.
